// File: rtl/sin_inverse_search.sv
// Inverts the sine-easing table: smallest x with sin_tab(x) >= target, 8-step binary search.
// Optional out_err port (sin_tab(out_x) - target) is built when SIN_INV_ERR_OUT_EN is defined.
module sin_inverse_search #(
    parameter int STICKY_LAST = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_target,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_x,
    output logic       out_exact
`ifdef SIN_INV_ERR_OUT_EN
    ,
    output logic [7:0] out_err
`endif
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam real PI = 3.14159265358979323846;

    // sin_tab(x) = round(127.5 * (1 - cos(pi * x / 256))), folded at elaboration
    logic [7:0] sin_tab [256];
    for (genvar i = 0; i < 256; i++) begin : g_tab
        localparam real ANG = PI * i / 256.0;
        localparam int VAL = $rtoi(127.5 * (1.0 - $cos(ANG)) + 0.5 + 1.0e-9);
        assign sin_tab[i] = VAL[7:0];
    end

    state_t     state_q, state_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] hv_q, hv_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] tgt_q, tgt_d;
    logic [7:0] x_q, x_d;
    logic       exact_q, exact_d;
    logic       valid_q, valid_d;
    logic       cache_vld_q, cache_vld_d;
    logic [7:0] cache_tgt_q, cache_tgt_d;
    logic [7:0] cache_x_q, cache_x_d;
    logic       cache_exact_q, cache_exact_d;
`ifdef SIN_INV_ERR_OUT_EN
    logic [7:0] err_q, err_d;
    logic [7:0] cache_err_q, cache_err_d;
`endif

    logic [7:0] mid;
    logic [7:0] tab_mid;
    logic       ge;

    assign mid     = 8'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
    assign tab_mid = sin_tab[mid];
    assign ge      = tab_mid >= tgt_q;

    // hv tracks sin_tab(hi), so the final value at lo==hi needs no second lookup
    always_comb begin
        state_d       = state_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        hv_d          = hv_q;
        cnt_d         = cnt_q;
        tgt_d         = tgt_q;
        x_d           = x_q;
        exact_d       = exact_q;
        valid_d       = valid_q;
        cache_vld_d   = cache_vld_q;
        cache_tgt_d   = cache_tgt_q;
        cache_x_d     = cache_x_q;
        cache_exact_d = cache_exact_q;
`ifdef SIN_INV_ERR_OUT_EN
        err_d         = err_q;
        cache_err_d   = cache_err_q;
`endif
        in_ready      = (state_q == IDLE) && !rst;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (STICKY_LAST != 0 && cache_vld_q &&
                        in_target == cache_tgt_q) begin
                        x_d     = cache_x_q;
                        exact_d = cache_exact_q;
`ifdef SIN_INV_ERR_OUT_EN
                        err_d   = cache_err_q;
`endif
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        tgt_d   = in_target;
                        lo_d    = 8'd0;
                        hi_d    = 8'd255;
                        hv_d    = 8'd255;
                        cnt_d   = 3'd0;
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (lo_q != hi_q) begin
                    if (ge) begin
                        hi_d = mid;
                        hv_d = tab_mid;
                    end else begin
                        lo_d = mid + 8'd1;
                    end
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    x_d     = lo_d;
                    exact_d = (hv_d == tgt_q);
`ifdef SIN_INV_ERR_OUT_EN
                    err_d   = hv_d - tgt_q;
`endif
                    valid_d = 1'b1;
                    state_d = DONE;
                    if (STICKY_LAST != 0) begin
                        cache_vld_d   = 1'b1;
                        cache_tgt_d   = tgt_q;
                        cache_x_d     = lo_d;
                        cache_exact_d = (hv_d == tgt_q);
`ifdef SIN_INV_ERR_OUT_EN
                        cache_err_d   = hv_d - tgt_q;
`endif
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lo_q          <= 8'd0;
            hi_q          <= 8'd0;
            hv_q          <= 8'd0;
            cnt_q         <= 3'd0;
            tgt_q         <= 8'd0;
            x_q           <= 8'd0;
            exact_q       <= 1'b0;
            valid_q       <= 1'b0;
            cache_vld_q   <= 1'b0;
            cache_tgt_q   <= 8'd0;
            cache_x_q     <= 8'd0;
            cache_exact_q <= 1'b0;
`ifdef SIN_INV_ERR_OUT_EN
            err_q         <= 8'd0;
            cache_err_q   <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            hv_q          <= hv_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            x_q           <= x_d;
            exact_q       <= exact_d;
            valid_q       <= valid_d;
            cache_vld_q   <= cache_vld_d;
            cache_tgt_q   <= cache_tgt_d;
            cache_x_q     <= cache_x_d;
            cache_exact_q <= cache_exact_d;
`ifdef SIN_INV_ERR_OUT_EN
            err_q         <= err_d;
            cache_err_q   <= cache_err_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_x     = x_q;
    assign out_exact = exact_q;
`ifdef SIN_INV_ERR_OUT_EN
    assign out_err   = err_q;
`endif

endmodule

// File: tb/tb_sin_inverse_search.sv
// Bench for sin_inverse_search: spec vectors, full target sweep with random
// backpressure, reset abort, and a STICKY_LAST=1 instance for the result cache.
module tb_sin_inverse_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_exact;
    logic [7:0] in_target, out_x;
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_exact;
    logic [7:0] s_in_target, s_out_x;
`ifdef SIN_INV_ERR_OUT_EN
    logic [7:0] out_err, s_out_err;
`endif

    sin_inverse_search #(.STICKY_LAST(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_exact(out_exact)
`ifdef SIN_INV_ERR_OUT_EN
        , .out_err(out_err)
`endif
    );

    sin_inverse_search #(.STICKY_LAST(1)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_target(s_in_target),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_x(s_out_x), .out_exact(s_out_exact)
`ifdef SIN_INV_ERR_OUT_EN
        , .out_err(s_out_err)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    bit stall_en = 0;
    bit seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] x;
        logic       exact;
        logic [7:0] err;
        int         due;
    } exp_t;

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] x;
        logic       exact;
        logic [7:0] err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    function automatic logic [7:0] ref_tab(input int i);
        real v;
        v = 127.5 * (1.0 - $cos(3.14159265358979323846 * i / 256.0));
        return 8'($rtoi(v + 0.5 + 1.0e-9));
    endfunction

    function automatic logic [7:0] ref_x(input logic [7:0] t);
        for (int i = 0; i < 256; i++)
            if (ref_tab(i) >= t) return 8'(i);
        return 8'hff;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Result monitor: latency on first valid cycle, payload on handshake
    always @(negedge clk) begin
        if (out_valid) begin
            if (!seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_valid: got out_x=%0d with no request pending", out_x);
                end else begin
                    chk("latency", cyc, sb[0].due);
                end
            end
            if (out_ready) begin
                seen = 0;
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_x", out_x, e.x);
                    chk("out_exact", out_exact, e.exact);
`ifdef SIN_INV_ERR_OUT_EN
                    chk("out_err", out_err, e.err);
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] t, input bit track);
        int n;
        exp_t e;
        logic [7:0] x;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        in_target = t;
        if (track) begin
            x = ref_x(t);
            e.x = x;
            e.exact = (ref_tab(int'(x)) == t);
            e.err = ref_tab(int'(x)) - t;
            e.due = cyc + 9;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_target = 8'($urandom);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic s_run(input string nm, input logic [7:0] t, input int lat,
                         input logic [7:0] ex, input logic ee, input logic [7:0] er);
        int n;
        int c;
        n = 0;
        @(negedge clk);
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        s_in_valid = 1'b1;
        s_in_target = t;
        c = cyc;
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_target = ~t;
        n = 0;
        while (!s_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, cyc - c, lat);
        chk({nm, "_x"}, s_out_x, ex);
        chk({nm, "_exact"}, s_out_exact, ee);
`ifdef SIN_INV_ERR_OUT_EN
        chk({nm, "_err"}, s_out_err, er);
`else
        if (er != 8'd0 && ee) n_bad++;
`endif
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_target = 8'd0;
        out_ready = 1'b1;
        s_in_valid = 1'b0;
        s_in_target = 8'd0;
        s_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_exact", out_exact, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);

        vecs[0] = '{8'd0,   8'd0,   1'b1, 8'd0};
        vecs[1] = '{8'd1,   8'd8,   1'b1, 8'd0};
        vecs[2] = '{8'd255, 8'd249, 1'b1, 8'd0};
        vecs[3] = '{8'd39,  8'd66,  1'b0, 8'd1};
        vecs[4] = '{8'd128, 8'd128, 1'b1, 8'd0};
        vecs[5] = '{8'd234, 8'd208, 1'b1, 8'd0};
        vecs[6] = '{8'd40,  8'd66,  1'b1, 8'd0};

        for (int i = 0; i < 7; i++) begin
            exp_t e;
            send(vecs[i].tgt, 1'b0);
            e.x = vecs[i].x;
            e.exact = vecs[i].exact;
            e.err = vecs[i].err;
            e.due = cyc + 8;
            sb.push_back(e);
            wait_empty();
        end

        stall_en = 1'b1;
        for (int t = 0; t < 256; t++) begin
            send(8'(t), 1'b1);
            wait_empty();
        end
        @(posedge clk);
        #3;
        stall_en = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        wait_empty();

        out_ready = 1'b0;
        send(8'd128, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_x", out_x, 128);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_in_ready", in_ready, 0);
        @(negedge clk);
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_in_ready_rise", in_ready, 1);
        wait_empty();

        send(8'd200, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_x", out_x, 0);
        chk("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("abort_no_valid", bad, 0);
        send(8'd1, 1'b1);
        wait_empty();

        s_run("s_first", 8'd39, 9, 8'd66, 1'b0, 8'd1);
        s_run("s_hit", 8'd39, 1, 8'd66, 1'b0, 8'd1);
        s_run("s_miss", 8'd40, 9, 8'd66, 1'b1, 8'd0);
        s_run("s_hit40", 8'd40, 1, 8'd66, 1'b1, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_run("s_after_rst", 8'd40, 9, 8'd66, 1'b1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sin_inverse_search.md
Name: sin_inverse_search

Overview:
- Inverse of the forward sine-easing table (sinTable): maps an eased 8-bit value back to its linear 8-bit index.
- Returns the smallest x in 0..255 for which sinTable(x) >= target, using a fixed-length binary search that consults one sinTable instance each cycle.
- Sits in the FPGA colour-fade path wherever a current eased LED level must be turned back into a ramp position before a fade restarts.
- Valid/ready handshakes on both the request and the result side.

Parameters:
- STICKY_LAST, 0. When 1, a one-entry result cache is enabled: a request whose target equals the last completed target returns the cached result without searching.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_target  input  8  eased value to invert
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_x  output  8  linear index: smallest x with sinTable(x) >= target
- out_exact  output  1  1 when sinTable(out_x) == target

Behaviour:
- States: IDLE, SEARCH, DONE.
- Reset: state=IDLE; out_valid=0; out_x=0; out_exact=0; iteration count=0; cache invalid. in_ready=0 while rst=1.
- in_ready = (state==IDLE) && !rst. Requests are not accepted in SEARCH or DONE.
- IDLE, on accept: latch target, set lo=0, hi=255, cnt=0, go to SEARCH.
  - If STICKY_LAST=1, the cache is valid and in_target equals the cached target: go directly to DONE with the cached out_x/out_exact.
- SEARCH: exactly 8 iterations, one per cycle, regardless of early convergence.
  - mid = (lo+hi)>>1, computed at 9 bits then truncated.
  - If sinTable(mid) >= target then hi=mid, else lo=mid+1.
  - Once lo==hi, later iterations leave lo and hi unchanged.
  - After the iteration with cnt==7: out_x=lo, out_exact=(sinTable(lo)==target), out_valid=1, go to DONE. Update the cache if it is enabled.
- Latency: the accept cycle is cycle 0; out_valid is high in cycle 9. A cache hit gives out_valid in cycle 1.
- DONE: out_valid, out_x and out_exact hold stable until out_ready=1. On that cycle's edge: out_valid=0, state=IDLE.
  - in_ready rises the following cycle, so there is no same-cycle accept. Minimum request period is 10 cycles (2 on a cache hit).
- Every target 0..255 has a solution because sinTable(255)=255, so no not-found case exists.
  - target=0 yields x=0.
  - For duplicated table values the lowest index is returned.
- Changes on in_target after acceptance are ignored.
- Reset mid-SEARCH or mid-DONE aborts the operation: outputs return to reset values, the cache is invalidated, and no result is produced.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro SIN_INV_ERR_OUT_EN.
- Defined: adds output out_err[7:0] = sinTable(out_x) - target.
  - Registered alongside out_x and held under the same handshake; reset value 0.
  - Always >= 0 by construction; 0 exactly when out_exact=1.
  - Included in the cache when STICKY_LAST=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then target=0 -> out_valid in cycle 9 with out_x=0, out_exact=1 (out_err=0 with macro).
- target=1 -> out_x=8, out_exact=1. target=255 -> out_x=249, out_exact=1 (lowest duplicate index).
- target=39 -> out_x=66, out_exact=0 (out_err=1). target=128 -> out_x=128, out_exact=1. target=234 -> out_x=208, out_exact=1.
- Backpressure: target=128 with out_ready=0 for 5 cycles -> out_valid and out_x=128 stay stable, in_ready=0 throughout; out_ready=1 -> out_valid=0 on the next cycle, in_ready=1 the cycle after.
- Reset asserted in SEARCH cycle 4 of target=200 -> out_valid never asserts; the next request target=1 completes normally with out_x=8.
- STICKY_LAST=1: target=39, then target=39 -> second result arrives in cycle 1 with out_x=66. Then target=40 -> full 9-cycle search with out_x=66, out_exact=1. Reset, then target=40 -> full search (cache invalidated).
